// File: rtl/mux_display_if.sv
// mux_display_if: bundles the display-scanner signals between a controller
// (master) and the scanner (slave).
//
//   en      : display enable (1 = scan, 0 = dark)
//   load    : one-cycle strobe capturing d0..d3 into the shadow registers
//   d0..d3  : digit codes, d0 rightmost, d3 leftmost
//   Q       : registered code of the selected digit, to the segment decoder
//   an      : active-low digit enables
//   digit   : index of the current or next digit
//   blank   : 1 while the current digit is suppressed
//   state   : scanner FSM state (debug visibility)
//
// Handshake: there is no valid/ready pair. load is a plain strobe sampled on
// every rising clock edge; the scanner always accepts it in the same cycle.
interface mux_display_if;
   logic       en;
   logic       load;
   logic [3:0] d0;
   logic [3:0] d1;
   logic [3:0] d2;
   logic [3:0] d3;
   logic [3:0] Q;
   logic [3:0] an;
   logic [1:0] digit;
   logic       blank;
   logic [1:0] state;

   modport master (
      output en, load, d0, d1, d2, d3,
      input  Q, an, digit, blank, state
   );

   modport slave (
      input  en, load, d0, d1, d2, d3,
      output Q, an, digit, blank, state
   );
endinterface

// File: rtl/mux_display.sv
// mux_display: time-multiplexed scanner for a four-digit seven-segment
// display. Four 4-bit codes are held in shadow registers; each digit is lit
// for DIV cycles followed by a one-cycle guard slot with all digits off.
//
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous reset, active-high
//   bus : mux_display_if.slave (en, load, d0..d3 in; Q, an, digit, blank,
//         state out)
//
// Parameter:
//   DIV : cycles each digit stays lit, 2 .. 2^20
//
// Optional feature macro:
//   BLANK_ZEROS_EN : leading-zero suppression. When undefined, blank is
//                    always 0 and every digit lights.
module mux_display #(
   parameter int unsigned DIV = 50000
) (
   input  logic   clk,
   input  logic   rst,
   mux_display_if.slave bus
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

   typedef enum logic [1:0] {
      OFF   = 2'd0,
      SCAN  = 2'd1,
      GUARD = 2'd2
   } state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [1:0]    digit, digit_nx;
   logic [3:0]    s0, s1, s2, s3;
   logic [3:0]    q, q_nx;
   logic [3:0]    entry_code;
   logic          entering_scan;
   logic          sup;
   logic [3:0]    an_w;

   // Shadow registers: capture on any load strobe, regardless of state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0 <= 4'd0;
         s1 <= 4'd0;
         s2 <= 4'd0;
         s3 <= 4'd0;
      end else if (bus.load) begin
         s0 <= bus.d0;
         s1 <= bus.d1;
         s2 <= bus.d2;
         s3 <= bus.d3;
      end
   end

   // Digit index increments on the SCAN->GUARD edge, so during the guard
   // cycle 'digit' already names the digit about to be lit.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      digit_nx = digit;
      if (!bus.en) begin
         state_nx = OFF;
         cnt_nx   = '0;
         digit_nx = 2'd0;
      end else begin
         case (state)
            OFF: begin
               state_nx = SCAN;
               cnt_nx   = '0;
            end
            SCAN: begin
               if (cnt == CNT_MAX) begin
                  state_nx = GUARD;
                  cnt_nx   = '0;
                  digit_nx = digit + 2'd1;
               end else begin
                  cnt_nx = cnt + 1'b1;
               end
            end
            GUARD: begin
               state_nx = SCAN;
               cnt_nx   = '0;
            end
            default: begin
               state_nx = OFF;
               cnt_nx   = '0;
               digit_nx = 2'd0;
            end
         endcase
      end
   end

   // Code of the digit being entered. Shadow values are the registered ones,
   // so a load on the same edge is not seen until the next slot.
   always_comb begin
      entry_code = s0;
      case (digit_nx)
         2'd0: entry_code = s0;
         2'd1: entry_code = s1;
         2'd2: entry_code = s2;
         2'd3: entry_code = s3;
         default: entry_code = s0;
      endcase
   end

   assign entering_scan = (state_nx == SCAN) && (state != SCAN);

   // Q only changes on SCAN entry so the segments never glitch mid-slot.
   always_comb begin
      q_nx = q;
      if (entering_scan) begin
         q_nx = entry_code;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= OFF;
         cnt   <= '0;
         digit <= 2'd0;
         q     <= 4'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         digit <= digit_nx;
         q     <= q_nx;
      end
   end

`ifdef BLANK_ZEROS_EN
   // A digit is suppressed when it and every digit to its left are zero.
   // Decided once at slot entry and held for the whole slot.
   logic sup_r;
   logic sup_entry;

   always_comb begin
      sup_entry = 1'b0;
      case (digit_nx)
         2'd1:    sup_entry = ((s1 | s2 | s3) == 4'd0);
         2'd2:    sup_entry = ((s2 | s3) == 4'd0);
         2'd3:    sup_entry = (s3 == 4'd0);
         default: sup_entry = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sup_r <= 1'b0;
      end else if (entering_scan) begin
         sup_r <= sup_entry;
      end
   end

   assign sup = sup_r;
`else
   assign sup = 1'b0;
`endif

   always_comb begin
      an_w = 4'b1111;
      if ((state == SCAN) && !sup) begin
         an_w[digit] = 1'b0;
      end
   end

   assign bus.Q     = q;
   assign bus.an    = an_w;
   assign bus.digit = digit;
   assign bus.blank = (state == SCAN) && sup;
   assign bus.state = state;

endmodule

// File: doc/mux_display.md
# mux_display

Time-multiplexed scanner for a four-digit seven-segment display. It holds four 4-bit digit codes in shadow registers and cycles through them at a prescaled rate. For each digit it drives the 4-bit code `Q` to the segment decoder directly downstream, and it drives the matching active-low digit-enable line. A one-cycle guard slot between digits, with all digits off, prevents ghosting.

## Interface
Parameters:
- `DIV`, default 50000: clock cycles each digit stays lit. Legal range is 2 to 2^20.

Ports:
- `clk`  in  1: system clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous reset, active-high.
- `en`  in  1: display enable. 1 = scan; 0 = dark.
- `load`  in  1: one-cycle strobe that captures `d0`–`d3` into the shadow registers.
- `d0`  in  4: code for digit 0 (rightmost).
- `d1`  in  4: code for digit 1.
- `d2`  in  4: code for digit 2.
- `d3`  in  4: code for digit 3 (leftmost).
- `Q`  out  4: registered code for the digit currently selected; feeds the decoder.
- `an`  out  4: active-low digit enables; `an[i]`=0 lights digit i.
- `digit`  out  2: index of the current or next digit.
- `blank`  out  1: 1 when the current digit is suppressed.

## Operation
- Shadow registers `s0`–`s3`:
  - Load on any cycle with `load`=1, in every state.
  - Otherwise they hold their value.
- Prescaler `cnt` counts 0 to `DIV`-1. It runs only in state SCAN and clears on every state change.
- State OFF:
  - `an`=1111, `blank`=0, `digit`=0.
  - Moves to SCAN when `en`=1.
- State SCAN:
  - Lights the digit selected by `digit`.
  - `Q`=`s[digit]`.
  - `an`=one-cold at `digit`, unless that digit is suppressed (see Configuration).
  - Moves to GUARD when `cnt`=`DIV`-1.
- State GUARD:
  - Lasts exactly one cycle with `an`=1111.
  - `digit` increments modulo 4 (3 wraps to 0).
  - Returns to SCAN.
- `en`=0 in any state forces OFF on the next edge. `en` has priority over the GUARD/SCAN transitions.
- `Q` is reloaded from the shadow registers only on entry to SCAN. A `load` during a lit digit does not change `Q` until the next digit begins; this gives glitch-free segments.

## Timing
- Reset values:
  - State OFF, `cnt`=0, `digit`=0.
  - `s0`–`s3`=0000.
  - `Q`=0000, `an`=1111, `blank`=0.
- Reset is asynchronous mid-scan. Outputs reach their reset values immediately, without waiting for an edge.
- Enabling: from `en`=1 sampled in OFF, `an`=1110 and `Q`=`s0` appear one cycle later.
- Each digit is lit for exactly `DIV` cycles, followed by 1 guard cycle. The full frame is 4·(`DIV`+1) cycles.
- `load` on cycle N: the shadow registers hold the new codes from N+1.
- If a `load` coincides with the SCAN-entry edge, the old shadow value is used on that edge.
- Disabling: from `en`=0 sampled, `an`=1111 and `digit`=0 one cycle later.

## Configuration
- `BLANK_ZEROS_EN` defined: leading-zero suppression.
  - On SCAN entry for digit k (k=1..3), the digit is suppressed when `s_k`..`s3` are all 0000.
  - A suppressed digit keeps `an`=1111 and sets `blank`=1 for its whole slot.
  - Digit 0 is never suppressed.
  - Slot timing is unchanged.
- Not defined: `blank` is tied to 0 and every digit lights.

## Test plan
Use `DIV`=4 for all scenarios.
- Reset, then `en`=0 for 20 cycles -> `an`=1111, `Q`=0000, `digit`=0 throughout.
- `load` with d3..d0=4,3,2,1, then `en`=1 -> `an` sequence is 1110×4, 1111, 1101×4, 1111, 1011×4, 1111, 0111×4, 1111, then repeats. `Q` during the lit slots is 1,2,3,4.
- `load` d0=9 during the second cycle of digit 0's slot -> `Q` stays 1 until the slot ends, and `Q`=9 on the next frame's digit-0 slot.
- `en` dropped during the digit-2 slot -> `an`=1111 and `digit`=0 next cycle. `en` reasserted -> restarts at digit 0.
- `rst` pulsed mid-slot, asynchronously -> `an`=1111 and `Q`=0000 before the next clock edge, and the shadow registers read 0 afterwards.
- With `BLANK_ZEROS_EN` and d3..d0=0,0,5,0 -> digits 3 and 2 are dark (`blank`=1, `an`=1111 in their slots); digits 1 and 0 light with `Q`=5 and `Q`=0.
